// File: rtl/spi_mem_arbiter.sv
// Round-robin two-port arbiter that serialises word requests into mode-0 SPI
// transactions {opcode, address, data byte} for a single external SPI RAM.
module spi_mem_arbiter #(
    parameter int          ADDR_W   = 16,
    parameter int          SCK_HALF = 1,
    parameter logic [7:0]  RD_OP    = 8'h03,
    parameter logic [7:0]  WR_OP    = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_wdata,
    output logic              p1_ack,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int NBITS = 16 + ADDR_W;
    localparam int HW    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BW    = $clog2(NBITS);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic              last_gnt;
    logic              gnt_port;
    logic              gnt_wr;
    logic [NBITS-1:0]  shreg;
    logic [6:0]        rx;
    logic [HW-1:0]     half_cnt;
    logic [BW-1:0]     bit_cnt;

    logic              pick;
    logic              pick_wr;
    logic [NBITS-1:0]  frame;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick = p1_req;
        if (p0_req && p1_req)
            pick = ~last_gnt;
        pick_wr = pick & p1_we;
        frame   = {RD_OP, p0_addr, 8'h00};
        if (pick)
            frame = {p1_we ? WR_OP : RD_OP, p1_addr, p1_we ? p1_wdata : 8'h00};
    end

    // NOTE: the block holds only flops (no memory arrays), so all of it takes the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_port <= 1'b0;
            gnt_wr   <= 1'b0;
            shreg    <= '0;
            rx       <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            busy     <= 1'b0;
            rdata    <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        state    <= SHIFT;
                        gnt_port <= pick;
                        last_gnt <= pick;
                        gnt_wr   <= pick_wr;
                        shreg    <= frame;
                        spi_mosi <= frame[NBITS-1];
                        spi_cs_n <= 1'b0;
                        spi_sck  <= 1'b0;
                        busy     <= 1'b1;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            // End of high phase: sample MISO and drop SCK.
                            rx      <= {rx[5:0], spi_miso};
                            spi_sck <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state    <= DONE;
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                p0_ack   <= ~gnt_port;
                                p1_ack   <= gnt_port;
                                if (!gnt_wr)
                                    rdata <= {rx, spi_miso};
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                shreg    <= shreg << 1;
                                spi_mosi <= shreg[NBITS-2];
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomised bench for spi_mem_arbiter: SPI RAM slave models, a reference
// memory/rdata model, and per-scenario tasks with inline comparisons.
module tb_spi_mem_arbiter;
    localparam int NB   = 32;
    // Counted in falling edges from the one where req is raised (E0 is the next rising edge).
    localparam int LAT1 = 2 * 1 * NB + 1;
    localparam int LAT2 = 2 * 2 * NB + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p1_wdata;
    logic        p0_ack, p1_ack, busy;
    logic [7:0]  rdata;
    logic        spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;

    logic        q0_req, q1_req, q1_we;
    logic [15:0] q0_addr, q1_addr;
    logic [7:0]  q1_wdata;
    logic        q0_ack, q1_ack, busy2;
    logic [7:0]  rdata2;
    logic        cs2_n, sck2, mosi2;
    logic        miso2 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rdata(rdata), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_mem_arbiter #(.SCK_HALF(2)) dut2 (
        .clk(clk), .rst(rst),
        .p0_req(q0_req), .p0_addr(q0_addr), .p0_ack(q0_ack),
        .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata), .p1_ack(q1_ack),
        .rdata(rdata2), .busy(busy2),
        .spi_cs_n(cs2_n), .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(miso2)
    );

    // SPI RAM device behind dut: captures MOSI on SCK rise, serves read bytes MSB-first.
    logic [7:0]  dev_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [7:0]  ref_rdata;
    logic [31:0] s_frame;
    logic [7:0]  s_out;
    int          s_bit = 0;
    logic [31:0] frames [$];

    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            if (s_bit == 32) begin
                frames.push_back(s_frame);
                if (s_frame[31:24] == 8'h02) dev_mem[s_frame[23:8]] = s_frame[7:0];
            end
            s_bit    = 0;
            spi_miso = 1'b0;
        end else begin
            s_frame = {s_frame[30:0], spi_mosi};
            s_bit++;
            if (s_bit == 24) s_out = dev_mem[s_frame[15:0]];
            if (s_bit >= 25) spi_miso = s_out[32 - s_bit];
        end
    end

    // Device behind dut2 returns addr[7:0]^5A; MISO is corrupted after each SCK fall.
    logic [31:0] s2_frame;
    logic [7:0]  s2_out;
    int          s2_bit = 0;
    logic [31:0] frames2 [$];

    always @(posedge sck2 or posedge cs2_n) begin
        if (cs2_n) begin
            if (s2_bit == 32) frames2.push_back(s2_frame);
            s2_bit = 0;
            miso2  = 1'b0;
        end else begin
            s2_frame = {s2_frame[30:0], mosi2};
            s2_bit++;
            if (s2_bit == 24) s2_out = s2_frame[7:0] ^ 8'h5A;
            if (s2_bit >= 25) miso2 = s2_out[32 - s2_bit];
        end
    end

    always @(negedge sck2) if (!cs2_n) miso2 = ~miso2;

    int   ack_overlap = 0;
    int   ack_wide    = 0;
    logic p0_prev = 1'b0, p1_prev = 1'b0;

    always @(negedge clk) begin
        if (p0_ack && p1_ack) ack_overlap++;
        if ((p0_ack && p0_prev) || (p1_ack && p1_prev)) ack_wide++;
        p0_prev = p0_ack;
        p1_prev = p1_ack;
    end

    function automatic logic [31:0] pop_frame();
        if (frames.size() == 0) return 32'hxxxx_xxxx;
        return frames.pop_front();
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_rdata = 8'h00;
    endtask

    // One transaction from one port; returns falling-edge count to ack (0 on timeout) and CS low cycles.
    task automatic do_txn(input bit port, input bit we, input logic [15:0] addr,
                          input logic [7:0] wd, output int lat, output int low);
        @(negedge clk);
        if (!port) begin
            p0_req = 1'b1; p0_addr = addr;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        lat = 0;
        low = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (!spi_cs_n) low++;
            if ((!port && p0_ack) || (port && p1_ack)) begin
                lat = k;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({spi_cs_n, spi_sck, busy} !== 3'b100) $display("FAIL reset_hold: got %b want 100", {spi_cs_n, spi_sck, busy});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({spi_cs_n, spi_sck, spi_mosi, p0_ack, p1_ack, busy} !== 6'b100000)
            $display("FAIL reset_outs: got %b want 100000", {spi_cs_n, spi_sck, spi_mosi, p0_ack, p1_ack, busy});
        else n_pass++;
        n_checks++;
        if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata);
        else n_pass++;
        n_checks++;
        if ({cs2_n, sck2, busy2, rdata2} !== {3'b100, 8'h00}) $display("FAIL reset_dut2: got %b want 10000000000", {cs2_n, sck2, busy2, rdata2});
        else n_pass++;
    endtask

    task automatic test_read_p0();
        int lat, low;
        logic [31:0] f;
        dev_mem[16'h1234] = 8'hA5;
        ref_mem[16'h1234] = 8'hA5;
        do_txn(1'b0, 1'b0, 16'h1234, 8'h00, lat, low);
        n_checks++;
        if (lat != LAT1) $display("FAIL read_p0_latency: got %0d want %0d", lat, LAT1);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL read_p0_busy_at_ack: got %b want 1", busy);
        else n_pass++;
        n_checks++;
        if (rdata !== 8'hA5) $display("FAIL read_p0_rdata: got %h want a5", rdata);
        else n_pass++;
        n_checks++;
        if (low != 64) $display("FAIL read_p0_cs_low: got %0d want 64", low);
        else n_pass++;
        f = pop_frame();
        n_checks++;
        if (f !== 32'h0312_3400) $display("FAIL read_p0_mosi: got %h want 03123400", f);
        else n_pass++;
        ref_rdata = 8'hA5;
    endtask

    task automatic test_write_p1();
        int lat, low;
        logic [31:0] f;
        do_txn(1'b1, 1'b1, 16'h00FF, 8'h5C, lat, low);
        ref_mem[16'h00FF] = 8'h5C;
        n_checks++;
        if (lat != LAT1) $display("FAIL write_p1_latency: got %0d want %0d", lat, LAT1);
        else n_pass++;
        n_checks++;
        if (rdata !== ref_rdata) $display("FAIL write_p1_rdata_kept: got %h want %h", rdata, ref_rdata);
        else n_pass++;
        f = pop_frame();
        n_checks++;
        if (f !== 32'h0200_FF5C) $display("FAIL write_p1_mosi: got %h want 0200ff5c", f);
        else n_pass++;
        do_txn(1'b0, 1'b0, 16'h00FF, 8'h00, lat, low);
        void'(pop_frame());
        n_checks++;
        if (rdata !== 8'h5C) $display("FAIL write_p1_readback: got %h want 5c", rdata);
        else n_pass++;
        ref_rdata = 8'h5C;
    endtask

    task automatic test_random();
        int lat, low;
        bit port, we;
        logic [15:0] addr;
        logic [7:0] wd;
        logic [31:0] f, ef;
        for (int i = 0; i < 12; i++) begin
            port = 1'($urandom_range(0, 1));
            we   = port ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = (i % 3 == 2) ? 16'h00FF : 16'($urandom);
            wd   = 8'($urandom);
            do_txn(port, we, addr, wd, lat, low);
            ef = {we ? 8'h02 : 8'h03, addr, we ? wd : 8'h00};
            if (we) ref_mem[addr] = wd;
            else ref_rdata = ref_mem[addr];
            n_checks++;
            if (lat != LAT1 || low != 64) $display("FAIL rand%0d_timing: got lat %0d low %0d want %0d 64", i, lat, low, LAT1);
            else n_pass++;
            f = pop_frame();
            n_checks++;
            if (f !== ef) $display("FAIL rand%0d_mosi: got %h want %h", i, f, ef);
            else n_pass++;
            n_checks++;
            if (rdata !== ref_rdata) $display("FAIL rand%0d_rdata: got %h want %h", i, rdata, ref_rdata);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int gaps[$];
        int hi;
        bit seen;
        int want;
        logic [31:0] f, ef;
        apply_reset();
        @(negedge clk);
        p0_req = 1'b1; p0_addr = 16'h0100;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0200; p1_wdata = 8'h3C;
        hi = 0;
        seen = 1'b0;
        for (int k = 0; k < 600 && order.size() < 4; k++) begin
            @(negedge clk);
            if (spi_cs_n) hi++;
            else if (hi > 0) begin
                if (seen) gaps.push_back(hi);
                hi = 0;
            end
            if (p0_ack) begin
                order.push_back(0);
                seen = 1'b1;
                n_checks++;
                if (rdata !== ref_mem[16'h0100]) $display("FAIL b2b_rdata: got %h want %h", rdata, ref_mem[16'h0100]);
                else n_pass++;
            end
            if (p1_ack) begin
                order.push_back(1);
                seen = 1'b1;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        ref_mem[16'h0200] = 8'h3C;
        ref_rdata = ref_mem[16'h0100];
        n_checks++;
        if (order.size() != 4) $display("FAIL b2b_count: got %0d want 4", order.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            want = i % 2;
            n_checks++;
            if ((order.size() > i ? order[i] : -1) != want)
                $display("FAIL b2b_grant%0d: got %0d want %0d", i, order.size() > i ? order[i] : -1, want);
            else n_pass++;
            ef = want ? 32'h0202_003C : 32'h0301_0000;
            f = pop_frame();
            n_checks++;
            if (f !== ef) $display("FAIL b2b_mosi%0d: got %h want %h", i, f, ef);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((gaps.size() > i ? gaps[i] : -1) != 2)
                $display("FAIL b2b_cs_gap%0d: got %0d want 2", i, gaps.size() > i ? gaps[i] : -1);
            else n_pass++;
        end
    endtask

    task automatic test_change_mid();
        logic [15:0] a;
        logic [31:0] f;
        int got;
        a = 16'($urandom);
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = a;
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_grant: got %b want 1", busy);
        else n_pass++;
        repeat (9) @(negedge clk);
        p1_addr = ~a; p1_we = 1'b1; p1_wdata = 8'($urandom); p1_req = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p1_ack) begin
                got = 1;
                break;
            end
        end
        ref_rdata = ref_mem[a];
        n_checks++;
        if (got != 1) $display("FAIL mid_ack: got %0d want 1", got);
        else n_pass++;
        f = pop_frame();
        n_checks++;
        if (f !== {8'h03, a, 8'h00}) $display("FAIL mid_mosi: got %h want %h", f, {8'h03, a, 8'h00});
        else n_pass++;
        n_checks++;
        if (rdata !== ref_rdata) $display("FAIL mid_rdata: got %h want %h", rdata, ref_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] c;
        logic [31:0] f;
        int acks, winner;
        c = 16'($urandom);
        @(negedge clk);
        p0_req = 1'b1; p0_addr = 16'($urandom);
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        repeat (29) @(negedge clk);
        n_checks++;
        if (spi_cs_n !== 1'b0) $display("FAIL rstmid_pre: got %b want 0", spi_cs_n);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({spi_cs_n, spi_sck, spi_mosi, busy, p0_ack, p1_ack} !== 6'b100000)
            $display("FAIL rstmid_async: got %b want 100000", {spi_cs_n, spi_sck, spi_mosi, busy, p0_ack, p1_ack});
        else n_pass++;
        p0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = 8'h00;
        acks = 0;
        repeat (80) begin
            @(negedge clk);
            if (p0_ack || p1_ack) acks++;
        end
        n_checks++;
        if (acks != 0 || frames.size() != 0) $display("FAIL rstmid_no_ack: got acks %0d frames %0d want 0 0", acks, frames.size());
        else n_pass++;
        @(negedge clk);
        p0_req = 1'b1; p0_addr = c;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = ~c;
        winner = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                winner = p1_ack ? 1 : 0;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        n_checks++;
        if (winner != 0) $display("FAIL rstmid_tie: got %0d want 0", winner);
        else n_pass++;
        f = pop_frame();
        n_checks++;
        if (f !== {8'h03, c, 8'h00}) $display("FAIL rstmid_mosi: got %h want %h", f, {8'h03, c, 8'h00});
        else n_pass++;
        ref_rdata = ref_mem[c];
        n_checks++;
        if (rdata !== ref_rdata) $display("FAIL rstmid_rdata: got %h want %h", rdata, ref_rdata);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_sck_half2();
        logic [15:0] a;
        logic [31:0] f;
        logic prev;
        int lat, run, bad;
        a = 16'($urandom);
        @(negedge clk);
        q0_req = 1'b1; q0_addr = a;
        lat = 0; run = 0; bad = 0; prev = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (!cs2_n) begin
                if (sck2 == prev) run++;
                else begin
                    if (run != 2) bad++;
                    run = 1;
                    prev = sck2;
                end
            end
            if (q0_ack) begin
                lat = k;
                break;
            end
        end
        q0_req = 1'b0;
        n_checks++;
        if (lat != LAT2) $display("FAIL half2_latency: got %0d want %0d", lat, LAT2);
        else n_pass++;
        n_checks++;
        if (bad != 0 || run != 2) $display("FAIL half2_phase: got bad %0d last %0d want 0 2", bad, run);
        else n_pass++;
        n_checks++;
        if (rdata2 !== (a[7:0] ^ 8'h5A)) $display("FAIL half2_rdata: got %h want %h", rdata2, a[7:0] ^ 8'h5A);
        else n_pass++;
        f = (frames2.size() > 0) ? frames2.pop_front() : 32'hxxxx_xxxx;
        n_checks++;
        if (f !== {8'h03, a, 8'h00}) $display("FAIL half2_mosi: got %h want %h", f, {8'h03, a, 8'h00});
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        q0_req = 1'b0; q0_addr = '0;
        q1_req = 1'b0; q1_we = 1'b0; q1_addr = '0; q1_wdata = '0;
        ref_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'($urandom);
            ref_mem[i] = dev_mem[i];
        end
        test_reset();
        test_read_p0();
        test_write_p1();
        test_random();
        test_back_to_back();
        test_change_mid();
        test_reset_mid();
        test_sck_half2();
        n_checks++;
        if (ack_overlap != 0 || ack_wide != 0) $display("FAIL ack_shape: got overlap %0d wide %0d want 0 0", ack_overlap, ack_wide);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
